// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared encodings for the divider controller
// Contents: divider start/ready levels, zero word, controller state encoding.
package div_ctrl_pkg;

  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;

  typedef enum logic [1:0] {
    DivCtrlIdle = 2'b00,
    DivCtrlBusy = 2'b01,
    DivCtrlDone = 2'b10
  } div_ctrl_state_e;

endpackage

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - EX-stage controller for the iterative 32-bit divider
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   div_req_i, signed_i      EX instruction is DIV/DIVU, 1 = signed
//   op1_i, op2_i             dividend / divisor from EX operand muxes
//   flush_i, ex_adv_i        pipeline kill / EX advances to MEM
//   div_start_o, div_annul_o divider start level / cancel
//   div_signed_o, div_op*_o  divider sign select and operands
//   div_result_i, div_ready_i divider {remainder, quotient} and ready
//   stall_req_o              stall request to the pipeline controller
//   result_valid_o, hi_o, lo_o captured remainder / quotient
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter bit ZDIV_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req_i,
  input  logic        signed_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        flush_i,
  input  logic        ex_adv_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        stall_req_o,
  output logic        result_valid_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  div_ctrl_state_e state_q;
  logic [31:0]     op1_q;
  logic [31:0]     op2_q;
  logic            signed_q;
  logic [31:0]     hi_q;
  logic [31:0]     lo_q;
  logic            valid_q;

  logic            accept;
  logic            zdiv_hit;
  logic            issue;

  // A request is taken in IDLE unless the same cycle is being flushed.
  assign accept   = (state_q == DivCtrlIdle) && div_req_i && !flush_i;
  assign zdiv_hit = ZDIV_BYPASS && (op2_i == ZeroWord);
  assign issue    = accept && !zdiv_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DivCtrlIdle;
      op1_q    <= ZeroWord;
      op2_q    <= ZeroWord;
      signed_q <= 1'b0;
      hi_q     <= ZeroWord;
      lo_q     <= ZeroWord;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        DivCtrlIdle: begin
          if (accept) begin
            op1_q    <= op1_i;
            op2_q    <= op2_i;
            signed_q <= signed_i;
            if (zdiv_hit) begin
              // Zero divisor is answered locally; the divider never starts.
              hi_q    <= ZeroWord;
              lo_q    <= ZeroWord;
              valid_q <= 1'b1;
              state_q <= DivCtrlDone;
            end else begin
              state_q <= DivCtrlBusy;
            end
          end
        end
        DivCtrlBusy: begin
          // Flush wins over a coincident ready: the result belongs to a killed instruction.
          if (flush_i) begin
            state_q <= DivCtrlIdle;
          end else if (div_ready_i == DivResultReady) begin
            hi_q    <= div_result_i[63:32];
            lo_q    <= div_result_i[31:0];
            valid_q <= 1'b1;
            state_q <= DivCtrlDone;
          end
        end
        DivCtrlDone: begin
          if (ex_adv_i || flush_i) begin
            valid_q <= 1'b0;
            state_q <= DivCtrlIdle;
          end
        end
        default: begin
          state_q <= DivCtrlIdle;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Operands come straight from EX only on the issue cycle; afterwards the
  // latched copies are driven because the divider re-reads the sign bits late.
  always_comb begin
    div_start_o  = DivStop;
    div_annul_o  = 1'b0;
    div_signed_o = 1'b0;
    div_op1_o    = ZeroWord;
    div_op2_o    = ZeroWord;
    stall_req_o  = 1'b0;
    case (state_q)
      DivCtrlIdle: begin
        stall_req_o = accept;
        if (issue) begin
          div_start_o  = DivStart;
          div_signed_o = signed_i;
          div_op1_o    = op1_i;
          div_op2_o    = op2_i;
        end
      end
      DivCtrlBusy: begin
        stall_req_o  = 1'b1;
        div_start_o  = flush_i ? DivStop : DivStart;
        div_annul_o  = flush_i;
        div_signed_o = signed_q;
        div_op1_o    = op1_q;
        div_op2_o    = op2_q;
      end
      DivCtrlDone: begin
        div_signed_o = signed_q;
        div_op1_o    = op1_q;
        div_op2_o    = op2_q;
      end
      default: begin
        stall_req_o = 1'b0;
      end
    endcase
  end

  assign result_valid_o = valid_q;
  assign hi_o           = hi_q;
  assign lo_o           = lo_q;

endmodule
